// File: rtl/ldtu_pkg.sv
// Shared LDTU constants: buffer geometry, idle word and serializer framing nibbles.
// Imported by the buffer controller and by serializer-side checkers.
package ldtu_pkg;

   localparam int Nbits_32       = 32;
   localparam int FifoDepth_buff = 64;
   localparam int bits_ptr       = 6;
   localparam int FullThr        = 62;
   localparam int bits_cnt       = 8;

   localparam logic [Nbits_32-1:0] IdleWord = 32'hEAAAAAAA;

   localparam logic [3:0] TrailerNibble = 4'b1101;
   localparam logic [3:0] InitialNibble = 4'b1111;

endpackage

// File: rtl/ldtu_sat_counter.sv
// Saturating up-counter with increment enable; holds at all-ones.
// Clears only on the asynchronous active-low reset.
module ldtu_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/ldtu_buffer_ctrl.sv
// Output buffer between the LDTU control unit and the serializer: circular
// word store, registered read port, early-full flag and loss/overflow statistics.
module ldtu_buffer_ctrl
   import ldtu_pkg::*;
(
   input  logic                CLK_,
   input  logic                reset_,
   input  logic                write_signal,
   input  logic [Nbits_32-1:0] DATA_from_CU,
   input  logic                losing_data,
   input  logic                read_signal,
   output logic [Nbits_32-1:0] DATA_out,
   output logic                data_valid,
   output logic                full,
   output logic                empty,
   output logic [bits_ptr:0]   occupancy,
   output logic [bits_cnt-1:0] overflow_cnt,
   output logic [bits_cnt-1:0] lost_cnt
);

   localparam logic [bits_ptr:0] DepthOcc = (bits_ptr+1)'(FifoDepth_buff);
   localparam logic [bits_ptr:0] FullOcc  = (bits_ptr+1)'(FullThr);

   logic [Nbits_32-1:0] mem_q [FifoDepth_buff];
   logic [bits_ptr-1:0] wr_ptr_q, rd_ptr_q;
   logic [bits_ptr:0]   occ_q, occ_d;
   logic [Nbits_32-1:0] dout_q;
   logic                valid_q;
   logic                rd_acc, wr_acc, wr_rej;

   // A write at true-full still succeeds when a read frees a slot the same cycle.
   always_comb begin
      rd_acc = read_signal && (occ_q != '0);
      wr_acc = write_signal && ((occ_q < DepthOcc) || rd_acc);
      wr_rej = write_signal && !wr_acc;
      occ_d  = occ_q;
      case ({wr_acc, rd_acc})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge CLK_) begin
      if (wr_acc)
         mem_q[wr_ptr_q] <= DATA_from_CU;
   end

   always_ff @(posedge CLK_ or negedge reset_) begin
      if (!reset_) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         dout_q   <= IdleWord;
         valid_q  <= 1'b0;
      end else begin
         occ_q <= occ_d;
         if (wr_acc)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (read_signal) begin
            if (rd_acc) begin
               dout_q   <= mem_q[rd_ptr_q];
               valid_q  <= 1'b1;
               rd_ptr_q <= rd_ptr_q + 1'b1;
            end else begin
               dout_q  <= IdleWord;
               valid_q <= 1'b0;
            end
         end
      end
   end

   ldtu_sat_counter #(.W(bits_cnt)) u_overflow_cnt (
      .clk_i  (CLK_),
      .rst_ni (reset_),
      .inc_i  (wr_rej),
      .cnt_o  (overflow_cnt)
   );

   ldtu_sat_counter #(.W(bits_cnt)) u_lost_cnt (
      .clk_i  (CLK_),
      .rst_ni (reset_),
      .inc_i  (losing_data),
      .cnt_o  (lost_cnt)
   );

   assign DATA_out   = dout_q;
   assign data_valid = valid_q;
   assign occupancy  = occ_q;
   assign full       = (occ_q >= FullOcc);
   assign empty      = (occ_q == '0);

endmodule
